// File: rtl/accum_dump_stage.sv
// accum_dump_stage: integrate-and-dump stage placed after the accumulator.
// Every DECIM valid samples it takes the difference of the running sum P
// against the previous dump. It then rounds or truncates, shifts and
// saturates that difference. Results go out through a 2-entry valid/ready buffer.
// Optional feature macro: ACCUM_DUMP_ROUND_EN
//   defined   -> round half up before the shift
//   undefined -> truncate toward minus infinity (no rounding adder)
module accum_dump_stage #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int DECIM = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic signed [IN_W-1:0]  P,
    output logic signed [OUT_W-1:0] Y,
    output logic                    y_valid_o,
    input  logic                    y_ready_i,
    output logic                    sat_o,
    output logic                    ovf_o
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    // Clamp limits expressed in the IN_W+1 bit working width.
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    // ---------------------------------------------------------------
    // Sample counter and dump difference
    // ---------------------------------------------------------------
    logic [CNT_W-1:0]       r_cnt;
    logic signed [IN_W-1:0] r_p_last;
    logic                   w_dump;
    logic signed [IN_W-1:0] w_diff;

    assign w_dump = en_i && (r_cnt == CNT_LAST);
    // Modular subtraction: a wrapped accumulator still gives the true window sum.
    assign w_diff = P - r_p_last;

    // Count valid samples and capture P on every dump.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_p_last <= '0;
        end else if (en_i) begin
            if (w_dump) begin
                r_cnt    <= '0;
                r_p_last <= P;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: registered window sum
    // ---------------------------------------------------------------
    logic signed [IN_W-1:0] r_s1_diff;
    logic                   r_s1_valid;

    // Register the window difference with its valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_diff  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_dump;
            if (w_dump) begin
                r_s1_diff <= w_diff;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: round/shift/saturate in IN_W+1 bits (no internal overflow)
    // ---------------------------------------------------------------
    logic signed [IN_W:0]    w_ext;
    logic signed [IN_W:0]    w_sum;
    logic signed [IN_W:0]    w_shift;
    logic                    w_hi;
    logic                    w_lo;
    logic signed [OUT_W-1:0] w_clamped;

    assign w_ext = {r_s1_diff[IN_W-1], r_s1_diff};
`ifdef ACCUM_DUMP_ROUND_EN
    localparam logic signed [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);
    assign w_sum = w_ext + RND;
`else
    assign w_sum = w_ext;
`endif
    assign w_shift = w_sum >>> SHIFT;
    assign w_hi    = (w_shift > MAX_V);
    assign w_lo    = (w_shift < MIN_V);

    // Pick the clamped or in-range value of the shifted window sum.
    always_comb begin
        w_clamped = w_shift[OUT_W-1:0];
        if (w_hi) begin
            w_clamped = MAX_V[OUT_W-1:0];
        end else if (w_lo) begin
            w_clamped = MIN_V[OUT_W-1:0];
        end
    end

    logic signed [OUT_W-1:0] r_s2_y;
    logic                    r_s2_valid;
    logic                    r_sat;

    // Register the stage 2 result and latch the sticky saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_y     <= '0;
            r_s2_valid <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y <= w_clamped;
                if (w_hi || w_lo) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // 2-entry output buffer: head register drives Y directly, tail behind it
    // ---------------------------------------------------------------
    logic signed [OUT_W-1:0] r_head;
    logic signed [OUT_W-1:0] r_tail;
    logic                    r_head_v;
    logic                    r_tail_v;
    logic                    r_ovf;
    logic signed [OUT_W-1:0] w_head_next;
    logic signed [OUT_W-1:0] w_tail_next;
    logic                    w_head_v_next;
    logic                    w_tail_v_next;
    logic                    w_drop;
    logic                    w_pop;

    assign w_pop = r_head_v && y_ready_i;

    // Apply the pop first, then place the push in the first free slot.
    always_comb begin
        w_head_next   = r_head;
        w_tail_next   = r_tail;
        w_head_v_next = r_head_v;
        w_tail_v_next = r_tail_v;
        w_drop        = 1'b0;
        if (w_pop) begin
            if (r_tail_v) begin
                w_head_next   = r_tail;
                w_tail_v_next = 1'b0;
            end else begin
                w_head_v_next = 1'b0;
            end
        end
        if (r_s2_valid) begin
            if (!w_head_v_next) begin
                w_head_next   = r_s2_y;
                w_head_v_next = 1'b1;
            end else if (!w_tail_v_next) begin
                w_tail_next   = r_s2_y;
                w_tail_v_next = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    // Buffer state and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_head_v <= 1'b0;
            r_tail_v <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_head   <= w_head_next;
            r_tail   <= w_tail_next;
            r_head_v <= w_head_v_next;
            r_tail_v <= w_tail_v_next;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign Y         = r_head;
    assign y_valid_o = r_head_v;
    assign sat_o     = r_sat;
    assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_accum_dump_stage.sv
// Testbench for accum_dump_stage (DECIM=4, SHIFT=2, OUT_W=16, IN_W=38).
// Expected results are queued when a dump is driven and compared in order
// against the outputs the consumer side accepts.
`timescale 1ns/1ps
module tb_accum_dump_stage;

    logic                clk = 1'b0;
    logic                reset;
    logic                en_i;
    logic signed [37:0]  P;
    logic signed [15:0]  Y;
    logic                y_valid_o;
    logic                y_ready_i;
    logic                sat_o;
    logic                ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [15:0] exp_q[$];
    logic signed [15:0] obs_q[$];

`ifdef ACCUM_DUMP_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    accum_dump_stage #(
        .IN_W  (38),
        .OUT_W (16),
        .SHIFT (2),
        .DECIM (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en_i),
        .P         (P),
        .Y         (Y),
        .y_valid_o (y_valid_o),
        .y_ready_i (y_ready_i),
        .sat_o     (sat_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk = ~clk;

    // Record every accepted output, sampled half a cycle before the pop edge.
    always @(negedge clk) begin
        if (!reset && y_valid_o && y_ready_i) begin
            obs_q.push_back(Y);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [37:0] p);
        en_i = 1'b1;
        P    = p;
        tick();
        en_i = 1'b0;
    endtask

    task automatic send_window(input logic signed [37:0] p);
        for (int i = 0; i < 4; i++) send(p);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en_i  = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        en_i      = 1'b0;
        P         = '0;
        y_ready_i = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if (y_valid_o !== 1'b0 || Y !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_out valid=%0b Y=%0d required valid=0 Y=0", y_valid_o, Y);
        end
        n_tests++;
        if (sat_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags sat=%0b ovf=%0b required 0 0", sat_o, ovf_o);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_first_window();
        logic signed [15:0] e, o;
        bit ok;
        e = ROUND ? 16'sd4 : 16'sd3;
        send(0); send(5); send(10);
        exp_q.push_back(e);
        send(15);
        n_tests++;
        if (y_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_t0 valid=%0b required 0", y_valid_o);
        end
        tick();
        n_tests++;
        if (y_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_t1 valid=%0b required 0", y_valid_o);
        end
        tick();
        n_tests++;
        if (y_valid_o !== 1'b1 || Y !== e) begin
            n_fail++;
            $display("FAIL latency_t2 valid=%0b Y=%0d required valid=1 Y=%0d", y_valid_o, Y, e);
        end
        exp_q.push_back(16'sd5);
        send(20); send(25); send(30); send(35);
        wait_obs(exp_q.size(), ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL first_window_timeout got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL first_window Y=%0d required %0d", o, e);
            end
            $display("[TB] first_window Y=%0d exp=%0d", o, e);
        end
    endtask

    task automatic test_negative();
        logic signed [15:0] e, o;
        bit ok;
        exp_q.push_back(ROUND ? -16'sd1 : -16'sd2);
        send(34); send(33); send(31); send(29);
        wait_obs(exp_q.size(), ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL negative_timeout got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL negative Y=%0d required %0d", o, e);
            end
            $display("[TB] negative Y=%0d exp=%0d", o, e);
        end
    endtask

    task automatic test_wrap();
        logic signed [15:0] e, o;
        bit ok;
        do_reset();
        // Bring P_last to 2^37-10 (that window itself clamps), then wrap.
        exp_q.push_back(16'sd32767);
        send_window(38'sh1F_FFFF_FFF6);
        exp_q.push_back(16'sd4);
        send_window(38'sh20_0000_0006);
        wait_obs(exp_q.size(), ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrap_timeout got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap Y=%0d required %0d", o, e);
            end
            $display("[TB] wrap Y=%0d exp=%0d", o, e);
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] e, o;
        bit ok;
        do_reset();
        n_tests++;
        if (sat_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_cleared sat=%0b required 0", sat_o);
        end
        // Exactly full-scale result: no clamping.
        exp_q.push_back(16'sd32767);
        send_window(38'sd131068);
        wait_obs(1, ok);
        n_tests++;
        if (!ok || sat_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_edge ok=%0b sat=%0b required ok=1 sat=0", ok, sat_o);
        end
        exp_q.push_back(16'sd32767);
        send_window(38'sd131068 + 38'sd1048576);
        wait_obs(2, ok);
        n_tests++;
        if (!ok || sat_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos_flag ok=%0b sat=%0b required ok=1 sat=1", ok, sat_o);
        end
        exp_q.push_back(-16'sd32768);
        send_window(38'sd131068);
        wait_obs(exp_q.size(), ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sat_timeout got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturation Y=%0d required %0d", o, e);
            end
            $display("[TB] saturation Y=%0d exp=%0d", o, e);
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] e, o;
        bit ok;
        do_reset();
        y_ready_i = 1'b0;
        send_window(38'sd4);
        send_window(38'sd12);
        tick(); tick(); tick();
        n_tests++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ovf_early ovf=%0b required 0", ovf_o);
        end
        send_window(38'sd24);
        tick(); tick(); tick();
        n_tests++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ovf ovf=%0b required 1", ovf_o);
        end
        n_tests++;
        if (y_valid_o !== 1'b1 || Y !== 16'sd1) begin
            n_fail++;
            $display("FAIL bp_hold valid=%0b Y=%0d required valid=1 Y=1", y_valid_o, Y);
        end
        tick(); tick();
        n_tests++;
        if (Y !== 16'sd1) begin
            n_fail++;
            $display("FAIL bp_stable Y=%0d required 1", Y);
        end
        exp_q.push_back(16'sd1);
        exp_q.push_back(16'sd2);
        y_ready_i = 1'b1;
        wait_obs(exp_q.size(), ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_timeout got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL backpressure Y=%0d required %0d", o, e);
            end
            $display("[TB] backpressure Y=%0d exp=%0d", o, e);
        end
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (obs_q.size() != 0 || y_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_dropped extra=%0d valid=%0b required 0 0", obs_q.size(), y_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] e, o;
        bit ok;
        do_reset();
        y_ready_i = 1'b0;
        send_window(38'sd8);
        send_window(38'sd20);
        n_tests++;
        if (y_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_setup valid=%0b required 1", y_valid_o);
        end
        // Reset with en_i also high: reset must win.
        reset = 1'b1;
        en_i  = 1'b1;
        P     = 38'sd99;
        tick();
        reset = 1'b0;
        en_i  = 1'b0;
        n_tests++;
        if (y_valid_o !== 1'b0 || Y !== 16'sd0 || sat_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_cleared valid=%0b Y=%0d sat=%0b ovf=%0b required 0 0 0 0",
                     y_valid_o, Y, sat_o, ovf_o);
        end
        y_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rm_stale got %0d outputs required 0", obs_q.size());
        end
        obs_q.delete();
        exp_q.push_back(ROUND ? 16'sd4 : 16'sd3);
        send(0); send(5); send(10); send(15);
        wait_obs(exp_q.size(), ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rm_timeout got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid Y=%0d required %0d", o, e);
            end
            $display("[TB] reset_mid Y=%0d exp=%0d", o, e);
        end
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rm_extra got %0d extra outputs required 0", obs_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        en_i      = 1'b0;
        P         = '0;
        y_ready_i = 1'b1;
        test_reset();
        test_first_window();
        test_negative();
        test_wrap();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
